// File: rtl/adc_seq_multich.sv
// Multi-channel SAR ADC conversion sequencer. It scans a masked channel list, averages
// 2^avg_log2 conversions per channel and hands out channel-tagged results over valid/ready.
module adc_seq_multich #(
  parameter int NCH          = 8,
  parameter int CH_W         = 3,
  parameter int RES          = 12,
  parameter int MAX_AVG_LOG2 = 4,
  parameter int SETTLE_CYC   = 4,
  parameter int TIMEOUT_CYC  = 1023
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_in,
  input  logic            mode_cont_in,
  input  logic            trigger_in,
  input  logic [NCH-1:0]  ch_mask_in,
  input  logic [2:0]      avg_log2_in,
  output logic [CH_W-1:0] chsel_out,
  output logic            start_conversion_out,
  input  logic            conversion_finished_in,
  input  logic [RES-1:0]  result_in,
  output logic [RES-1:0]  result_out,
  output logic [CH_W-1:0] result_ch_out,
  output logic            result_err_out,
  output logic            result_valid_out,
  input  logic            result_ready_in,
  output logic            busy_out
);

  localparam int ACC_W = RES + MAX_AVG_LOG2;
  localparam int NS_W  = MAX_AVG_LOG2 + 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST  = (SETTLE_CYC > 1) ? SET_W'(SETTLE_CYC - 1) : '0;
  localparam logic [TMO_W-1:0] TIMEOUT_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       AVG_MAX      = 3'(MAX_AVG_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_OUT} state_t;

  state_t           state_q, state_d;
  logic             fin_q;
  logic [NCH-1:0]   mask_q;
  logic [2:0]       avg_q;
  logic             cont_q;
  logic             abort_q;
  logic             err_q;
  logic [ACC_W-1:0] acc_q;
  logic [NS_W-1:0]  nsamp_q;
  logic [SET_W-1:0] settle_q;
  logic [TMO_W-1:0] tmo_q;

  logic             rise, last_sample, tmo_hit, abort, has_next;
  logic [CH_W-1:0]  next_ch;
  logic [2:0]       avg_clamped;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NCH-1:0] mask);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (mask[i]) lowest_set = CH_W'(i);
  endfunction

  assign rise        = conversion_finished_in & ~fin_q;
  assign last_sample = (nsamp_q + NS_W'(1)) == (NS_W'(1) << avg_q);
  assign tmo_hit     = tmo_q == TIMEOUT_LAST;
  assign abort       = abort_q | ~enable_in;
  assign avg_clamped = (avg_log2_in > AVG_MAX) ? AVG_MAX : avg_log2_in;

  // Next enabled channel above the current one; falls back to the lowest (wrap) if none.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    next_ch  = lowest_set(mask_q);
    has_next = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(chsel_out))) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (trigger_in && enable_in && |ch_mask_in) state_d = S_SETTLE;
      S_SETTLE: if (!enable_in) state_d = S_IDLE;
                else if (settle_q == SETTLE_LAST) state_d = S_START;
      S_START:  state_d = enable_in ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (rise) state_d = abort ? S_IDLE : (last_sample ? S_OUT : S_START);
        else if (tmo_hit) state_d = abort ? S_IDLE : S_OUT;
      end
      S_OUT: begin
        if (result_ready_in)
          state_d = (!enable_in || (!has_next && !cont_q)) ? S_IDLE : S_SETTLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fin_q     <= 1'b0;
      mask_q    <= '0;
      avg_q     <= '0;
      cont_q    <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      acc_q     <= '0;
      nsamp_q   <= '0;
      settle_q  <= '0;
      tmo_q     <= '0;
      chsel_out <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      fin_q   <= conversion_finished_in;
      unique case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (state_d == S_SETTLE) begin
            mask_q    <= ch_mask_in;
            avg_q     <= avg_clamped;
            cont_q    <= mode_cont_in;
            chsel_out <= lowest_set(ch_mask_in);
            acc_q     <= '0;
            nsamp_q   <= '0;
            err_q     <= 1'b0;
            settle_q  <= '0;
          end
        end
        S_SETTLE: settle_q <= settle_q + SET_W'(1);
        S_START:  tmo_q <= '0;
        S_WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (!enable_in) abort_q <= 1'b1;
          if (rise) begin
            acc_q   <= acc_q + ACC_W'(result_in);
            nsamp_q <= nsamp_q + NS_W'(1);
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (state_d == S_SETTLE) begin
            chsel_out <= next_ch;
            acc_q     <= '0;
            nsamp_q   <= '0;
            err_q     <= 1'b0;
            settle_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // A timed-out channel reports zero regardless of any partial sum.
  assign start_conversion_out = (state_q == S_START) && enable_in;
  assign busy_out             = state_q != S_IDLE;
  assign result_valid_out     = state_q == S_OUT;
  assign result_ch_out        = result_valid_out ? chsel_out : '0;
  assign result_err_out       = result_valid_out && err_q;
  assign result_out           = (result_valid_out && !err_q) ? RES'(acc_q >> avg_q) : '0;

endmodule

// File: doc/adc_seq_multich.md
Name: adc_seq_multich

Overview:
Parametrised multi-channel conversion sequencer with oversampling and averaging for the SAR ADC. It sits between system control and the ADC top level. It steps an external analog input mux through a masked channel list and issues one-cycle start pulses to the ADC. For each channel it accumulates 2^avg_log2 results, then emits one averaged, channel-tagged result through a valid/ready handshake. It supports single-shot and continuous scan modes, mux settling delay and a per-conversion timeout.

Parameters:
NCH, 8, number of input channels (2..16)
CH_W, 3, channel index width; must equal clog2(NCH)
RES, 12, ADC result width
MAX_AVG_LOG2, 4, largest supported averaging exponent (up to 16 samples)
SETTLE_CYC, 4, clk cycles to wait after chsel_out changes, before start (0 allowed)
TIMEOUT_CYC, 1023, clk cycles to wait for conversion_finished_in after start

Ports:
clk  in  1  sequencer clock
rst_n  in  1  asynchronous active-low reset
enable_in  in  1  block enable; low aborts the scan
mode_cont_in  in  1  1 = continuous scan, 0 = single scan
trigger_in  in  1  one-cycle pulse that starts a scan (single mode), or the first scan (continuous mode)
ch_mask_in  in  NCH  enabled channels; bit i = channel i
avg_log2_in  in  3  averaging exponent; values above MAX_AVG_LOG2 are clamped to it
chsel_out  out  CH_W  analog mux channel select
start_conversion_out  out  1  one-cycle start pulse to the ADC
conversion_finished_in  in  1  ADC done level; its rising edge marks a valid result
result_in  in  RES  ADC result; valid in the cycle of the finished rising edge
result_out  out  RES  averaged result
result_ch_out  out  CH_W  channel tag for result_out
result_err_out  out  1  1 = timeout occurred during this channel
result_valid_out  out  1  result valid
result_ready_in  in  1  consumer ready
busy_out  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator, sample counter and edge-detect register cleared.
- Edge detect: conversion_finished_in is registered; rise = in & ~in_q.
- Latched at scan start (trigger_in accepted in IDLE with enable_in=1): ch_mask_in, clamped avg_log2, mode_cont_in. These stay stable for the whole scan.
- Mask all zero at trigger: the trigger is ignored; the block stays in IDLE.
- Channel order: ascending enabled indices, starting from the lowest set bit. After the highest set bit, continuous mode wraps to the lowest set bit; single mode returns to IDLE.
- States:
  - IDLE: waits for trigger_in & enable_in. On accept, loads chsel_out with the first enabled channel and clears the accumulator -> SETTLE.
  - SETTLE: counts SETTLE_CYC cycles -> START. With SETTLE_CYC = 0 it goes directly to START on the next cycle.
  - START: start_conversion_out = 1 for exactly one cycle; the timeout counter is cleared -> WAIT.
  - WAIT: on rise, acc += result_in. If samples taken == 2^avg_log2 -> OUT, else -> START. If TIMEOUT_CYC cycles pass without a rise, set the channel's err flag -> OUT.
  - OUT: drives result_out = acc >> avg_log2 (truncating), result_ch_out, result_err_out, result_valid_out = 1. Holds all of these stable until result_ready_in = 1 (transfer cycle). The cycle after the transfer: valid drops; the next channel is loaded, the accumulator and err flag are cleared -> SETTLE, or -> IDLE at the end of a single scan.
- Back-pressure: the sequencer stalls in OUT; no conversion starts while a result is pending, so results are never lost.
- Accumulator width is RES+MAX_AVG_LOG2 and cannot overflow. With avg_log2 = 0, result_out = result_in.
- On timeout: result_out = 0, result_err_out = 1, and the remaining samples for that channel are skipped.
- enable_in low:
  - In SETTLE or START: go to IDLE next cycle; no start pulse is issued.
  - In WAIT: continue until rise or timeout, then discard the data and go to IDLE without emitting.
  - In OUT: complete the pending handshake, then go to IDLE.
  - trigger_in is ignored while busy_out = 1.
- A rise outside WAIT is ignored.
- Asynchronous reset at any time returns the block to the reset values immediately.

Test Plan:
- Single scan, mask = 8'b0010_0101, avg_log2 = 0, SETTLE_CYC = 4, ADC model returns 100+ch after 10 cycles, ready tied 1 -> results (ch0, 100), (ch2, 102), (ch5, 105). Each start pulse comes 4 cycles after a chsel change; busy_out falls after ch5.
- Averaging, avg_log2 = 2, ADC returns 10, 11, 12, 14 on ch3 -> 4 start pulses, then result_out = 11 (47>>2), result_ch_out = 3. avg_log2_in = 7 -> clamped to 4, 16 starts.
- Back-pressure: ready held low 50 cycles in OUT -> result_out/ch/valid stable throughout, no start pulse, one transfer when ready rises.
- Timeout: the ADC never asserts finished on ch1 (TIMEOUT_CYC = 1023) -> after 1023 cycles, result_err_out = 1, result_out = 0; the scan continues with the next enabled channel.
- Continuous mode, mask = 0x81 -> channel sequence 0, 7, 0, 7, … Dropping enable_in during WAIT -> the current result is discarded and the block goes to IDLE. A mask of 0 at trigger -> busy_out stays 0.
- Reset asserted in WAIT mid-average -> all outputs 0 at once. A later trigger restarts from the lowest enabled channel with a cleared accumulator.
